// File: rtl/steer_en_ctrl.sv
// -----------------------------------------------------------------------------
// steer_en_ctrl
// Rider-detect and steering-enable sequencer in front of balance_cntrl.
// Qualifies left/right load-cell samples and produces:
//   rider_off    - no rider present, PID integrator held clear
//   en_steer     - differential steering input applied
//   ld_cell_diff - signed lft_ld-rght_ld, saturated to 12 bits
// Steering is enabled only after the rider has stayed balanced for
// TMR_CYCLES consecutive clocks.
// -----------------------------------------------------------------------------
module steer_en_ctrl #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter int          TMR_W        = 26,
  parameter int          TMR_CYCLES   = 2**26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        rider_off,
  output logic        en_steer,
  output logic [11:0] ld_cell_diff
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] STEER = 2'd2;

  // Rider counts as gone only below the hysteresis band.
  localparam logic [12:0]      GONE_WT = {1'b0, MIN_RIDER_WT - WT_HYST};
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TMR_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  logic [1:0]        r_state;
  logic [TMR_W-1:0]  r_timer;
  logic              r_rider_off;
  logic              r_en_steer;
  logic [11:0]       r_ld_cell_diff;

  logic [12:0]        w_sum;
  logic signed [12:0] w_diff;
  logic [12:0]        w_abs_diff;
  logic [11:0]        w_diff_sat;
  logic               w_present;
  logic               w_gone;
  logic               w_balanced;
  logic               w_step_off;
  logic               w_tmr_done;
  logic [1:0]         w_nxt_state;
  logic [TMR_W-1:0]   w_nxt_timer;

  // Load-cell arithmetic and qualification predicates.
  always_comb begin
    w_sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
    w_diff     = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
    // |diff| is at most 4095, so the 13-bit negate cannot overflow.
    w_abs_diff = w_diff[12] ? 13'(-w_diff) : 13'(w_diff);
    if (w_diff > 13'sd2047)
      w_diff_sat = 12'h7FF;
    else if (w_diff < -13'sd2048)
      w_diff_sat = 12'h800;
    else
      w_diff_sat = w_diff[11:0];
    w_present  = (w_sum > {1'b0, MIN_RIDER_WT});
    w_gone     = (w_sum < GONE_WT);
    w_balanced = (w_abs_diff < (w_sum >> 2));
    w_step_off = (w_abs_diff > (w_sum - (w_sum >> 4)));
    w_tmr_done = (r_timer == TMR_MAX);
  end

  // Next-state decode; transitions happen only on valid samples.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_nxt_state unassigned
    // and infers a latch.
    w_nxt_state = r_state;
    if (vld) begin
      case (r_state)
        IDLE:    if (w_present) w_nxt_state = WAIT;
        WAIT: begin
          if (w_gone)                        w_nxt_state = IDLE;
          else if (w_balanced && w_tmr_done) w_nxt_state = STEER;
        end
        STEER: begin
          if (w_gone)          w_nxt_state = IDLE;
          else if (w_step_off) w_nxt_state = WAIT;
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  // Balance timer: runs only while remaining in WAIT, restarts on imbalance.
  always_comb begin
    w_nxt_timer = '0;
    if (r_state == WAIT && w_nxt_state == WAIT) begin
      if (vld && !w_balanced)
        w_nxt_timer = '0;
      else if (w_tmr_done)
        w_nxt_timer = r_timer;
      else
        w_nxt_timer = r_timer + TMR_ONE;
    end
  end

  // State, timer and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_rider_off    <= 1'b1;
      r_en_steer     <= 1'b0;
      r_ld_cell_diff <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_timer     <= w_nxt_timer;
      r_rider_off <= (w_nxt_state == IDLE);
      r_en_steer  <= (w_nxt_state == STEER);
      if (vld)
        r_ld_cell_diff <= w_diff_sat;
    end
  end

  assign rider_off    = r_rider_off;
  assign en_steer     = r_en_steer;
  assign ld_cell_diff = r_ld_cell_diff;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// -----------------------------------------------------------------------------
// tb_steer_en_ctrl
// Scoreboard bench for steer_en_ctrl. A driver applies directed and random
// load-cell samples on the falling edge and pushes the reference model's
// expected outputs; a monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_steer_en_ctrl;

  localparam int TMR_CYCLES = 16;
  localparam int MIN_WT     = 'h200;
  localparam int HYST       = 'h040;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        rider_off;
  logic        en_steer;
  logic [11:0] ld_cell_diff;

  steer_en_ctrl #(
    .MIN_RIDER_WT(12'h200),
    .WT_HYST     (12'h040),
    .TMR_W       (5),
    .TMR_CYCLES  (TMR_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vld         (vld),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .rider_off   (rider_off),
    .en_steer    (en_steer),
    .ld_cell_diff(ld_cell_diff)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ro;
    logic        en;
    logic [11:0] diff;
  } exp_t;

  typedef enum int {NO_RIDER, SETTLING, STEERING} mode_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: rider mode, clocks of uninterrupted balance, last diff.
  mode_t m_mode = NO_RIDER;
  int    m_bal_clks = 0;
  int    m_diff = 0;

  function automatic int clip12(int d);
    if (d > 2047)  return 2047;
    if (d < -2048) return -2048;
    return d;
  endfunction

  task automatic model_step(input bit r, input bit v, input int l, input int rr);
    int    sum, d, ad;
    bit    present, gone, bal, step;
    mode_t nxt;
    exp_t  e;
    if (r) begin
      m_mode = NO_RIDER;
      m_bal_clks = 0;
      m_diff = 0;
    end else begin
      sum = l + rr;
      d   = l - rr;
      ad  = (d < 0) ? -d : d;
      present = sum > MIN_WT;
      gone    = sum < (MIN_WT - HYST);
      bal     = ad < (sum / 4);
      step    = ad > (sum - sum / 16);
      nxt = m_mode;
      if (v) begin
        if (m_mode == NO_RIDER && present) nxt = SETTLING;
        else if (m_mode != NO_RIDER && gone) nxt = NO_RIDER;
        else if (m_mode == SETTLING && bal && m_bal_clks >= TMR_CYCLES - 1) nxt = STEERING;
        else if (m_mode == STEERING && step) nxt = SETTLING;
      end
      if (m_mode == SETTLING && nxt == SETTLING)
        m_bal_clks = (v && !bal) ? 0 : ((m_bal_clks + 1 > TMR_CYCLES - 1) ? TMR_CYCLES - 1 : m_bal_clks + 1);
      else
        m_bal_clks = 0;
      m_mode = nxt;
      if (v) m_diff = clip12(d);
    end
    e.ro   = (m_mode == NO_RIDER);
    e.en   = (m_mode == STEERING);
    e.diff = 12'(m_diff);
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit v, input int l, input int rr);
    @(negedge clk);
    rst     = r;
    vld     = v;
    lft_ld  = 12'(l);
    rght_ld = 12'(rr);
    model_step(r, v, l & 'hFFF, rr & 'hFFF);
  endtask

  task automatic drive_n(input int n, input bit r, input bit v, input int l, input int rr);
    for (int i = 0; i < n; i++) drive(r, v, l, rr);
  endtask

  // Monitor: one scoreboard entry is due after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (rider_off !== e.ro || en_steer !== e.en || ld_cell_diff !== e.diff) begin
          n_fail++;
          $display("FAIL outputs @%0t: got ro=%b en=%b diff=%h, expected ro=%b en=%b diff=%h",
                   $time, rider_off, en_steer, ld_cell_diff, e.ro, e.en, e.diff);
        end
      end
    end
  end

  initial begin
    int prof, base, n;
    rst = 1'b1; vld = 1'b0; lft_ld = '0; rght_ld = '0;

    // 1: reset with rider present, then settle and enable steering.
    drive_n(3, 1, 1, 'h180, 'h180);
    drive_n(20, 0, 1, 'h180, 'h180);
    // 2: strongly unbalanced load in WAIT restarts the timer.
    drive_n(2, 1, 1, 'h180, 'h180);
    drive_n(5, 0, 1, 'h180, 'h180);
    drive(0, 1, 'h300, 'h080);
    drive_n(18, 0, 1, 'h180, 'h180);
    // 3: step-off from STEER drops back to WAIT.
    drive(0, 1, 'h3F0, 'h008);
    drive_n(18, 0, 1, 'h180, 'h180);
    // 4: hysteresis band holds, lower weight drops the rider.
    drive_n(3, 0, 1, 'h0F0, 'h0F0);
    drive_n(2, 0, 1, 'h0D0, 'h0D0);
    // 5: no sample strobe keeps IDLE and diff; saturation both ways.
    drive_n(4, 0, 0, 'h180, 'h180);
    drive(0, 1, 'hFFF, 'h000);
    drive(0, 1, 'h000, 'hFFF);
    drive(0, 0, 'h123, 'h456);
    // 6: reset mid-STEER, then full restart.
    drive_n(20, 0, 1, 'h180, 'h180);
    drive(1, 1, 'h180, 'h180);
    drive_n(20, 0, 1, 'h180, 'h180);

    // Random segments with per-segment load profiles.
    for (int s = 0; s < 80; s++) begin
      prof = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) drive(1, $urandom_range(0, 1), $urandom_range(0, 'hFFF), $urandom_range(0, 'hFFF));
      n = $urandom_range(8, 30);
      for (int i = 0; i < n; i++) begin
        base = $urandom_range('h100, 'h300);
        case (prof)
          0: drive(0, 1, base + $urandom_range(0, 'h20), base);
          1: drive(0, $urandom_range(0, 3) != 0, base + $urandom_range(0, 'h60), base);
          2: drive(0, 1, $urandom_range('hC0, 'h110), $urandom_range('hC0, 'h110));
          3: drive(0, $urandom_range(0, 1), $urandom_range(0, 'hFFF), $urandom_range(0, 'hFFF));
          default: drive(0, 1, $urandom_range(0, 'h400), $urandom_range(0, 'h40));
        endcase
      end
    end

    // Drain: every pushed expectation must have been compared.
    @(posedge clk); #2;
    @(posedge clk); #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
